// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC-driven imem req/ack, 2-entry instruction queue to decode
module instruction_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ReadAddress,
    input  logic                  flush,
    output logic                  pc_advance,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  push_slot;
    logic [1:0]            count;
    logic [ADDR_WIDTH-1:0] q_pc   [2];
    logic [INST_WIDTH-1:0] q_data [2];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && count < 2'd2) begin
                    issue     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ack)
                    state_nxt = IDLE;
                else if (flush)
                    state_nxt = DROP;
            end
            // request cannot be withdrawn, so wait out the ack and discard it
            DROP: begin
                if (imem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (issue)
                imem_addr <= ReadAddress;
        end
    end

    assign imem_req   = (state != IDLE);
    assign push       = (state == REQ) && imem_ack && !flush;
    assign pc_advance = push;
    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = q_data[0];
    assign inst_pc    = q_pc[0];

    // write slot is the first free entry after any same-cycle pop has shifted the queue
    assign push_slot  = pop ? count[1] : count[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
            end
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                q_pc[0]   <= q_pc[1];
                q_data[0] <= q_data[1];
            end
            if (push) begin
                q_pc[push_slot]   <= imem_addr;
                q_data[push_slot] <= imem_rdata;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // a single outstanding request issued only below full means a push never meets a full queue
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == 2'd2));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ReadAddress = 32'h40;
    logic        flush = 1'b0;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          adv_cnt = 0;
    int          last_adv = 0;
    int          adv_gap = 0;
    int          base = 0;
    int          budget = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_val = 32'h0;
    logic [63:0] exp_q [$];

    instruction_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ReadAddress(ReadAddress),
        .flush      (flush),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    // program counter: redirect load wins over the advance pulse
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_load)
            ReadAddress <= pc_val;
        else if (pc_advance)
            ReadAddress <= ReadAddress + 32'd4;
        if (pc_advance) begin
            adv_cnt  <= adv_cnt + 1;
            adv_gap  <= cyc - last_adv;
            last_adv <= cyc;
        end
    end

    // memory: acks after ack_delay waiting cycles, word = {C0DE, addr[15:0]}, at most budget acks
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            imem_ack = 1'b0;
            if (imem_req && budget > 0) begin
                if (wait_cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = {16'hC0DE, imem_addr[15:0]};
                    budget     = budget - 1;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // monitor: every accepted instruction must match the scoreboard head
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %0h data %0h required no instruction", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", {32'h0, inst_pc}, {32'h0, e[63:32]});
                    check("pop_data", {32'h0, inst_data}, {32'h0, e[31:0]});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        rst        = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        budget     = 0;
        ack_delay  = 0;
        exp_q.delete();
        pc_load    = 1'b1;
        pc_val     = pc;
        tick(2);
        pc_load    = 1'b0;
        rst        = 1'b1;
        base       = adv_cnt;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_q.push_back({pc, 16'hC0DE, pc[15:0]});
    endtask

    initial begin
        // reset values, then asynchronous reset in the middle of a request
        tick(2);
        check("rst_req", {63'h0, imem_req}, 64'h0);
        check("rst_valid", {63'h0, inst_valid}, 64'h0);
        check("rst_adv", {63'h0, pc_advance}, 64'h0);
        check("rst_addr", {32'h0, imem_addr}, 64'h0);
        check("rst_data", {32'h0, inst_data}, 64'h0);
        check("rst_pc", {32'h0, inst_pc}, 64'h0);
        rst = 1'b1;
        tick(1);
        check("t1_req_up", {63'h0, imem_req}, 64'h1);
        check("t1_addr40", {32'h0, imem_addr}, 64'h40);
        #1 rst = 1'b0;
        #1;
        check("t1_async_req", {63'h0, imem_req}, 64'h0);
        check("t1_async_addr", {32'h0, imem_addr}, 64'h0);
        check("t1_async_valid", {63'h0, inst_valid}, 64'h0);
        pc_load = 1'b1;
        pc_val  = 32'h100;
        tick(1);
        pc_load = 1'b0;
        rst     = 1'b1;
        tick(1);
        check("t1_req_100", {63'h0, imem_req}, 64'h1);
        check("t1_addr_100", {32'h0, imem_addr}, 64'h100);

        // zero-wait stream
        do_reset(32'h0);
        budget     = 3;
        inst_ready = 1'b1;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        tick(14);
        check("t2_drained", 64'(exp_q.size()), 64'h0);
        check("t2_adv_cnt", 64'(adv_cnt - base), 64'd3);
        check("t2_adv_gap", 64'(adv_gap), 64'd2);

        // backpressure: queue fills, fetch stalls, one pop reopens it
        do_reset(32'h0);
        budget = 3;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        tick(10);
        check("t3_full_req", {63'h0, imem_req}, 64'h0);
        check("t3_full_valid", {63'h0, inst_valid}, 64'h1);
        check("t3_full_head", {32'h0, inst_pc}, 64'h0);
        check("t3_full_adv", 64'(adv_cnt - base), 64'd2);
        tick(4);
        check("t3_still_req", {63'h0, imem_req}, 64'h0);
        check("t3_still_adv", 64'(adv_cnt - base), 64'd2);
        inst_ready = 1'b1;
        tick(1);
        check("t3_head_4", {32'h0, inst_pc}, 64'h4);
        tick(1);
        check("t3_reissue", {63'h0, imem_req}, 64'h1);
        check("t3_reissue_addr", {32'h0, imem_addr}, 64'h8);
        tick(8);
        check("t3_drained", 64'(exp_q.size()), 64'h0);
        check("t3_adv_cnt", 64'(adv_cnt - base), 64'd3);

        // flush while waiting: DROP holds the request and discards the late word
        do_reset(32'h0);
        ack_delay  = 3;
        budget     = 1;
        inst_ready = 1'b1;
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_drop_req0", {63'h0, imem_req}, 64'h1);
        tick(1);
        check("t4_drop_req1", {63'h0, imem_req}, 64'h1);
        tick(1);
        check("t4_drop_req2", {63'h0, imem_req}, 64'h1);
        tick(1);
        check("t4_idle_req", {63'h0, imem_req}, 64'h0);
        check("t4_valid", {63'h0, inst_valid}, 64'h0);
        tick(2);
        check("t4_refetch_addr", {32'h0, imem_addr}, 64'h0);
        check("t4_adv", 64'(adv_cnt - base), 64'd0);

        // flush coinciding with ack, one entry buffered, redirect to 0x200
        do_reset(32'h0);
        budget = 2;
        tick(2);
        check("t5_one_entry", {63'h0, inst_valid}, 64'h1);
        tick(1);
        check("t5_req4", {32'h0, imem_addr}, 64'h4);
        flush   = 1'b1;
        pc_load = 1'b1;
        pc_val  = 32'h200;
        #2;
        check("t5_adv_masked", {63'h0, pc_advance}, 64'h0);
        tick(1);
        flush   = 1'b0;
        pc_load = 1'b0;
        check("t5_emptied", {63'h0, inst_valid}, 64'h0);
        check("t5_idle", {63'h0, imem_req}, 64'h0);
        budget     = 1;
        inst_ready = 1'b1;
        expect_word(32'h200);
        tick(1);
        check("t5_redirect_req", {63'h0, imem_req}, 64'h1);
        check("t5_redirect_addr", {32'h0, imem_addr}, 64'h200);
        tick(6);
        check("t5_drained", 64'(exp_q.size()), 64'h0);
        check("t5_adv_cnt", 64'(adv_cnt - base), 64'd2);

        // push and pop in the same cycle at count 1
        do_reset(32'h0);
        budget = 2;
        expect_word(32'h0);
        expect_word(32'h4);
        tick(3);
        inst_ready = 1'b1;
        tick(1);
        inst_ready = 1'b0;
        check("t6_valid", {63'h0, inst_valid}, 64'h1);
        check("t6_head_pc", {32'h0, inst_pc}, 64'h4);
        check("t6_head_data", {32'h0, inst_data}, 64'hC0DE0004);
        inst_ready = 1'b1;
        tick(4);
        check("t6_drained", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of the program counter: it takes the current `ReadAddress`, requests the instruction word from instruction memory over a req/ack handshake, and buffers returned words with their PC in a 2-entry queue that feeds decode through a valid/ready interface. It tells the program counter when to advance, one pulse per accepted fetch. It discards in-flight and buffered instructions on a redirect (`flush`).

## Interface
- `ADDR_WIDTH`, 32, width of instruction addresses / PC
- `INST_WIDTH`, 32, width of an instruction word
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `ReadAddress`  in  ADDR_WIDTH  current PC from program counter
- `flush`  in  1  redirect; discard outstanding and buffered fetches
- `pc_advance`  out  1  one-cycle pulse: program counter steps to next address
- `imem_req`  out  1  request to instruction memory
- `imem_addr`  out  ADDR_WIDTH  request address, stable while `imem_req`=1
- `imem_ack`  in  1  memory response valid (sampled only while `imem_req`=1)
- `imem_rdata`  in  INST_WIDTH  instruction word, valid with `imem_ack`
- `inst_valid`  out  1  queue head holds an instruction
- `inst_ready`  in  1  decode accepts head this cycle
- `inst_data`  out  INST_WIDTH  instruction at queue head
- `inst_pc`  out  ADDR_WIDTH  address of instruction at queue head

## Operation
- Reset (`rst`=0): state IDLE, queue count 0, `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `pc_advance`=0. Applies immediately, mid-transaction included; an ack arriving after reset release with `imem_req`=0 is ignored.
- FSM states: IDLE, REQ, DROP.
  - IDLE: if `flush`=0 and count < 2 → register `imem_addr`=`ReadAddress`, `imem_req`=1, go REQ. Else stay.
  - REQ: `imem_req` held 1, `imem_addr` held. On `imem_ack`=1 and `flush`=0 → push {`imem_addr`, `imem_rdata`}, `imem_req`=0, go IDLE. On `imem_ack`=1 and `flush`=1 → discard word, `imem_req`=0, go IDLE. On `imem_ack`=0 and `flush`=1 → go DROP.
  - DROP: `imem_req` held 1 until ack (protocol never withdraws a request); on ack discard word, `imem_req`=0, go IDLE. `flush` in DROP has no further effect.
- `pc_advance` = (state==REQ) & `imem_ack` & ~`flush`, combinational; never asserted in IDLE or DROP.
- Queue: 2 entries, count 0..2, `inst_valid` = (count != 0), head drives `inst_data`/`inst_pc`. Pop when `inst_valid` & `inst_ready`. Push and pop in same cycle: count unchanged, ordering preserved. Overflow impossible: request issued only when count < 2 and a single request is outstanding; push with count==2 is a design error (assertion).
- `flush`=1 (any state): count ← 0 at the edge; a same-cycle pop is irrelevant; no request issued in that cycle.

## Timing
- Request issue: `imem_req` rises the edge after IDLE sees count < 2 and `flush`=0.
- Zero-wait memory (ack in first REQ cycle): 2-cycle fetch period (REQ, IDLE), one instruction per 2 clocks peak.
- Pushed instruction visible on `inst_valid` the cycle after the ack edge.
- `pc_advance` coincides with the ack cycle; program counter updates at that edge, so the next IDLE cycle samples the new `ReadAddress`.
- Flush-to-first-new-request: 1 cycle from IDLE/REQ-with-ack; from DROP, 1 cycle after the pending ack.

## Test plan
- Reset: drive `rst`=0 mid-REQ with `imem_req`=1 → all outputs 0 asynchronously, state IDLE; release, `ReadAddress`=0x100 → `imem_req`=1, `imem_addr`=0x100 next edge.
- Zero-wait stream: ack every REQ cycle, `inst_ready`=1, PC stepping 0x0,0x4,0x8 → `inst_pc` 0x0,0x4,0x8 in order, one `pc_advance` per word, 2 clocks apart.
- Backpressure: `inst_ready`=0 → after 2 words queue full, `imem_req` stays 0, `pc_advance` never fires; raise `inst_ready` → head 0x0 popped, new request issued.
- Flush during wait: ack delayed 3 cycles, `flush` pulse on cycle 1 → DROP, `imem_req` held until ack, word discarded, no `pc_advance`, `inst_valid`=0.
- Flush with ack same cycle, queue holding 1 entry → queue empty, word discarded, `pc_advance`=0, next request uses redirected `ReadAddress`=0x200.
- Simultaneous push/pop at count 1 → count stays 1, `inst_data` advances to the newly fetched word.
